// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: write-back initiator for the 32x64 register file.
//
// Each cycle it merges a single-cycle ALU result with load results that arrive on a
// valid/ready handshake. Load results wait in a small FIFO. One result per cycle is
// driven to the register file write port. A per-register busy scoreboard tracks
// pending writes for the issue logic.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   alu_valid/rd/data ALU result. It is always accepted and has priority.
//   lsu_valid/ready   load-result handshake. A transfer occurs when both are high.
//   lsu_rd/data       load destination and data
//   issue_valid/rd    reserves a destination register in the scoreboard
//   alu_hold          asks upstream to keep alu_valid low so the FIFO can drain
//   wen               a real write is being driven this cycle (rd != 0)
//   rdAddr/dataBack   register file write address and data (registered)
//   busy              bit i set while a write to register i is pending; bit 0 is 0
module regfile_wb_writer #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        alu_hold,
  output logic        wen,
  output logic [4:0]  rdAddr,
  output logic [63:0] dataBack,
  output logic [31:0] busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
  localparam logic [StW-1:0]  StarveLim = StW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            alu_hold_q, alu_hold_d;
  logic            wen_q, wen_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [63:0]     data_back_q, data_back_d;
  logic [31:0]     busy_q, busy_d;

  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   alu_win;
  logic   sel_valid;
  entry_t sel;

  always_comb begin
    fifo_empty = (count_q == '0);
    lsu_ready  = (count_q != CntFull);
    push       = lsu_valid & lsu_ready;
    // While alu_hold is high, the FIFO pops even if the ALU (illegally) presents a result.
    pop        = !fifo_empty & (!alu_valid | alu_hold_q);
    alu_win    = alu_valid & !pop;
    sel_valid  = alu_win | pop;

    sel = '0;
    if (alu_win) begin
      sel.rd   = alu_rd;
      sel.data = alu_data;
    end else if (pop) begin
      sel = mem_q[rd_ptr_q];
    end
  end

  // FIFO next state. The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].rd   = lsu_rd;
      mem_d[wr_ptr_q].data = lsu_data;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation tracking. The counter saturates at the limit and clears on any pop.
  // alu_hold follows the next count, so it drops the cycle after the pop.
  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (alu_win && !fifo_empty && (starve_q != StarveLim)) begin
      starve_d = starve_q + StW'(1);
    end
    alu_hold_d = (starve_d == StarveLim);
  end

  // The output stage drives zeros when idle so the register file writes into the x0 sink.
  always_comb begin
    rd_addr_d   = sel.rd;
    data_back_d = sel.data;
    wen_d       = sel_valid & (sel.rd != 5'd0);
  end

  // Scoreboard. The clear comes from the write being driven now. A same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_hold_q  <= 1'b0;
      wen_q       <= 1'b0;
      rd_addr_q   <= '0;
      data_back_q <= '0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_hold_q  <= alu_hold_d;
      wen_q       <= wen_d;
      rd_addr_q   <= rd_addr_d;
      data_back_q <= data_back_d;
      busy_q      <= busy_d;
    end
  end

  // Storage needs no reset. Entries are only read after they have been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign alu_hold = alu_hold_q;
  assign wen      = wen_q;
  assign rdAddr   = rd_addr_q;
  assign dataBack = data_back_q;
  assign busy     = busy_q;

  // Upstream must keep alu_valid low while hold is asserted.
  alu_during_hold: assert property (@(posedge clk) disable iff (rst) !(alu_valid && alu_hold_q))
    else $error("alu_valid asserted while alu_hold is high");

endmodule

// File: tb/tb_regfile_wb_writer.sv
module tb_regfile_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_hold;
  logic        wen;
  logic [4:0]  rdAddr;
  logic [63:0] dataBack;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Register file model: no enable, captures every cycle, x0 is a sink.
  logic [63:0] rf [32];

  regfile_wb_writer #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_hold    (alu_hold),
    .wen         (wen),
    .rdAddr      (rdAddr),
    .dataBack    (dataBack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rdAddr != 5'd0) begin
      rf[rdAddr] <= dataBack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; issue_valid = 1'b0; issue_rd = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset, then idle.
    for (int i = 0; i < 5; i++) tick();
    chk("idle_rdaddr", 64'(rdAddr), 64'd0);
    chk("idle_data", dataBack, 64'd0);
    chk("idle_wen", 64'(wen), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(lsu_ready), 64'd1);
    chk("idle_hold", 64'(alu_hold), 64'd0);

    // A single ALU write appears one cycle later.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    chk("alu_rdaddr", 64'(rdAddr), 64'd5);
    chk("alu_data", dataBack, 64'h1234);
    chk("alu_wen", 64'(wen), 64'd1);
    alu_valid = 1'b0;
    tick();
    chk("alu_rf5", rf[5], 64'h1234);
    chk("alu_after_wen", 64'(wen), 64'd0);

    // Loads queue up behind a continuous ALU stream until alu_hold forces them through.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 64'hA0A0;
    tick();
    chk("st_a_ready", 64'(lsu_ready), 64'd1);
    chk("st_a_rdaddr", 64'(rdAddr), 64'd1);
    lsu_rd = 5'd11; lsu_data = 64'hB0B0;
    tick();
    chk("st_b_ready", 64'(lsu_ready), 64'd0);
    chk("st_b_hold", 64'(alu_hold), 64'd0);
    lsu_rd = 5'd12; lsu_data = 64'hC0C0;
    tick();
    chk("st_c_hold", 64'(alu_hold), 64'd0);
    tick();
    chk("st_d_hold", 64'(alu_hold), 64'd0);
    chk("st_d_rdaddr", 64'(rdAddr), 64'd1);
    tick();
    chk("st_e_hold", 64'(alu_hold), 64'd1);
    alu_valid = 1'b0;
    tick();
    chk("st_f_rdaddr", 64'(rdAddr), 64'd10);
    chk("st_f_data", dataBack, 64'hA0A0);
    chk("st_f_wen", 64'(wen), 64'd1);
    chk("st_f_hold", 64'(alu_hold), 64'd0);
    chk("st_f_ready", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    chk("st_g_rdaddr", 64'(rdAddr), 64'd11);
    chk("st_g_data", dataBack, 64'hB0B0);
    tick();
    chk("st_h_rdaddr", 64'(rdAddr), 64'd12);
    chk("st_h_data", dataBack, 64'hC0C0);
    chk("st_h_rf11", rf[11], 64'hB0B0);
    tick();
    chk("st_idle_wen", 64'(wen), 64'd0);
    chk("st_rf12", rf[12], 64'hC0C0);

    // The scoreboard sets on issue and clears on write-back.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("sb_busy_c1", 64'(busy), 64'h80);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    tick();
    alu_valid = 1'b0;
    chk("sb_busy_c2", 64'(busy), 64'h80);
    chk("sb_wen7", 64'(wen), 64'd1);
    tick();
    chk("sb_busy_clr", 64'(busy), 64'd0);
    // A re-issue in the same cycle as the write keeps the register busy.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h78;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    chk("sb_reissue_wen", 64'(wen), 64'd1);
    tick();
    issue_valid = 1'b0;
    chk("sb_reissue_busy", 64'(busy), 64'h80);
    tick();
    chk("sb_hold_busy", 64'(busy), 64'h80);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h79;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("sb_final_clr", 64'(busy), 64'd0);

    // A write to x0 carries its data but never enables a write.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    tick();
    alu_valid = 1'b0;
    chk("x0_rdaddr", 64'(rdAddr), 64'd0);
    chk("x0_wen", 64'(wen), 64'd0);
    chk("x0_data", dataBack, 64'hFFFF);
    chk("x0_busy", 64'(busy), 64'd0);
    tick();

    // Reset with a full FIFO and pending busy bits discards everything.
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    tick();
    issue_valid = 1'b0;
    chk("rst_pre_busy", 64'(busy), 64'hC00);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h0;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 64'hDEAD;
    tick();
    lsu_rd = 5'd11; lsu_data = 64'hBEEF;
    tick();
    chk("rst_pre_full", 64'(lsu_ready), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_rdaddr", 64'(rdAddr), 64'd0);
    chk("rst_data", dataBack, 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd1);
    chk("rst_hold", 64'(alu_hold), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_drain_wen", 64'(wen), 64'd0);
    end
    chk("rst_rf10", rf[10], 64'd0);
    chk("rst_rf11", rf[11], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
